proc_control_fsm: RTL and testbench

//  Multicycle control unit for the 16-bit processor datapath. It decodes the instruction held in IR,
//  and steps through T0..T3. Each step it drives the one-hot bus-select word for the shared bus

---
 rtl/proc_control_fsm.sv | 137 +++++++++++++
 tb/tb_proc_control_fsm.sv | 125 ++++++++++++
 2 files changed

// File: rtl/proc_control_fsm.sv
// Multicycle control unit: steps T0..T3 per instruction, decoding IR into the
// one-hot shared-bus select, datapath load enables and ALU operation.
module proc_control_fsm #(
  parameter int SEL_W   = 13,
  parameter int NREG    = 8,
  parameter int ALUOP_W = 3
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Run,
  input  logic [15:0]        IR,
  output logic [SEL_W-1:0]   bus_sel,
  output logic               ir_in,
  output logic [NREG-1:0]    r_in,
  output logic               a_in,
  output logic               g_in,
  output logic               h_in,
  output logic               i_in,
  output logic               j_in,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_H   = 4'd9;
  localparam logic [3:0] SEL_I   = 4'd10;
  localparam logic [3:0] SEL_J   = 4'd11;
  localparam logic [3:0] SEL_DIN = 4'd12;

  tstep_t               r_tstep;
  tstep_t               w_nextStep;
  logic [3:0]           w_opcode;
  logic [2:0]           w_x;
  logic [2:0]           w_y;
  logic                 w_isAlu;
  logic [ALUOP_W-1:0]   w_aluOp;
  logic [3:0]           w_resSel;
  logic [3:0]           w_loadGhij;
  logic                 w_unusedIrBits;

  assign w_opcode       = IR[15:12];
  assign w_x            = IR[11:9];
  assign w_y            = IR[8:6];
  assign w_isAlu        = (w_opcode >= 4'd2) && (w_opcode <= 4'd6);
  assign w_unusedIrBits = ^IR[5:0];

  always_ff @(posedge Clock) begin
    if (!Resetn) r_tstep <= T0;
    else         r_tstep <= w_nextStep;
  end

  // MV, MVI and undefined opcodes finish in T1; ALU ops run through T3.
  always_comb begin
    w_nextStep = T0;
    unique case (r_tstep)
      T0: w_nextStep = Run ? T1 : T0;
      T1: w_nextStep = w_isAlu ? T2 : T0;
      T2: w_nextStep = w_isAlu ? T3 : T0;
      T3: w_nextStep = T0;
    endcase
  end

  // Each ALU op owns one result register: its load enable in T2 and its bus source in T3.
  always_comb begin
    w_aluOp    = '0;
    w_resSel   = SEL_G;
    w_loadGhij = 4'b0000;
    case (w_opcode)
      4'd2: begin w_aluOp = ALUOP_W'(0); w_resSel = SEL_G; w_loadGhij = 4'b1000; end
      4'd3: begin w_aluOp = ALUOP_W'(1); w_resSel = SEL_G; w_loadGhij = 4'b1000; end
      4'd4: begin w_aluOp = ALUOP_W'(2); w_resSel = SEL_H; w_loadGhij = 4'b0100; end
      4'd5: begin w_aluOp = ALUOP_W'(3); w_resSel = SEL_I; w_loadGhij = 4'b0010; end
      4'd6: begin w_aluOp = ALUOP_W'(4); w_resSel = SEL_J; w_loadGhij = 4'b0001; end
      default: ;
    endcase
  end

  always_comb begin
    bus_sel = '0;
    ir_in   = 1'b0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    h_in    = 1'b0;
    i_in    = 1'b0;
    j_in    = 1'b0;
    alu_op  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    // Gating on Resetn keeps every enable off at the reset edge, even mid-instruction.
    if (Resetn) begin
      unique case (r_tstep)
        T0: ir_in = Run;
        T1: begin
          busy = 1'b1;
          if (w_opcode == 4'd0) begin
            bus_sel[w_y] = 1'b1;
            r_in[w_x]    = 1'b1;
            done         = 1'b1;
          end else if (w_opcode == 4'd1) begin
            bus_sel[SEL_DIN] = 1'b1;
            r_in[w_x]        = 1'b1;
            done             = 1'b1;
          end else if (w_isAlu) begin
            bus_sel[w_x] = 1'b1;
            a_in         = 1'b1;
          end else begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        end
        T2: begin
          busy = 1'b1;
          if (w_isAlu) begin
            bus_sel[w_y]              = 1'b1;
            alu_op                    = w_aluOp;
            {g_in, h_in, i_in, j_in} = w_loadGhij;
          end
        end
        T3: begin
          busy = 1'b1;
          if (w_isAlu) begin
            bus_sel[w_resSel] = 1'b1;
            r_in[w_x]         = 1'b1;
            done              = 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed testbench for proc_control_fsm: drives Run/IR/Resetn cycle by cycle
// and compares the full packed output word against hand-computed values.
module tb_proc_control_fsm;

  logic        Clock;
  logic        Resetn;
  logic        Run;
  logic [15:0] IR;
  logic [12:0] bus_sel;
  logic        ir_in;
  logic [7:0]  r_in;
  logic        a_in, g_in, h_in, i_in, j_in;
  logic [2:0]  alu_op;
  logic        busy, done, illegal;

  int numCompared   = 0;
  int numMismatched = 0;

  logic [32:0] obsVec;
  localparam logic [32:0] ZERO = 33'd0;

  proc_control_fsm dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .IR(IR),
    .bus_sel(bus_sel), .ir_in(ir_in), .r_in(r_in),
    .a_in(a_in), .g_in(g_in), .h_in(h_in), .i_in(i_in), .j_in(j_in),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal)
  );

  assign obsVec = {bus_sel, ir_in, r_in, a_in, g_in, h_in, i_in, j_in, alu_op, busy, done, illegal};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // ctl = {a,g,h,i,j}; st = {busy,done,illegal}
  function automatic logic [32:0] expVec(input logic [12:0] bus, input logic irIn,
                                         input logic [7:0] rIn, input logic [4:0] ctl,
                                         input logic [2:0] op, input logic [2:0] st);
    return {bus, irIn, rIn, ctl, op, st};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check mid-cycle, move past the next edge.
  task automatic applyStimulus(input string tag, input logic rstn, input logic run,
                               input logic [15:0] ir, input logic [32:0] expected);
    Resetn = rstn;
    Run    = run;
    IR     = ir;
    #2;
    checkOutput(tag, 64'(obsVec), 64'(expected));
    checkOutput({tag, "_busOneHot"}, 64'($countones(bus_sel) <= 1), 64'd1);
    checkOutput({tag, "_rInOneHot"}, 64'($countones(r_in) <= 1), 64'd1);
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Resetn = 1'b0;
    Run    = 1'b0;
    IR     = 16'h0000;

    applyStimulus("rst0",   1'b0, 1'b1, 16'h2340, ZERO);
    applyStimulus("rst1",   1'b0, 1'b1, 16'h2340, ZERO);
    applyStimulus("idle0",  1'b1, 1'b0, 16'h0000, ZERO);
    applyStimulus("idle1",  1'b1, 1'b0, 16'h0000, ZERO);

    applyStimulus("mviT0",  1'b1, 1'b1, 16'h1400, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("mviT1",  1'b1, 1'b0, 16'h1400, expVec(13'h1000, 1'b0, 8'h04, 5'b00000, 3'd0, 3'b110));
    applyStimulus("mviEnd", 1'b1, 1'b0, 16'h1400, ZERO);

    applyStimulus("addT0",  1'b1, 1'b1, 16'h2340, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("addT1",  1'b1, 1'b0, 16'h2340, expVec(13'h0002, 1'b0, 8'h00, 5'b10000, 3'd0, 3'b100));
    applyStimulus("addT2",  1'b1, 1'b0, 16'h2340, expVec(13'h0020, 1'b0, 8'h00, 5'b01000, 3'd0, 3'b100));
    applyStimulus("addT3",  1'b1, 1'b0, 16'h2340, expVec(13'h0100, 1'b0, 8'h02, 5'b00000, 3'd0, 3'b110));
    applyStimulus("addEnd", 1'b1, 1'b0, 16'h2340, ZERO);

    applyStimulus("xorT0",  1'b1, 1'b1, 16'h6E00, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("xorT1",  1'b1, 1'b1, 16'h6E00, expVec(13'h0080, 1'b0, 8'h00, 5'b10000, 3'd0, 3'b100));
    applyStimulus("xorT2",  1'b1, 1'b1, 16'h6E00, expVec(13'h0001, 1'b0, 8'h00, 5'b00001, 3'd4, 3'b100));
    applyStimulus("xorT3",  1'b1, 1'b1, 16'h6E00, expVec(13'h0800, 1'b0, 8'h80, 5'b00000, 3'd0, 3'b110));
    applyStimulus("b2bT0",  1'b1, 1'b1, 16'h0780, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("mvT1",   1'b1, 1'b0, 16'h0780, expVec(13'h0040, 1'b0, 8'h08, 5'b00000, 3'd0, 3'b110));
    applyStimulus("mvEnd",  1'b1, 1'b0, 16'h0780, ZERO);

    applyStimulus("illT0",  1'b1, 1'b1, 16'hF000, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("illT1",  1'b1, 1'b0, 16'hF000, expVec(13'h0000, 1'b0, 8'h00, 5'b00000, 3'd0, 3'b111));
    applyStimulus("illEnd", 1'b1, 1'b0, 16'hF000, ZERO);
    applyStimulus("ill7T0", 1'b1, 1'b1, 16'h7000, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("ill7T1", 1'b1, 1'b0, 16'h7000, expVec(13'h0000, 1'b0, 8'h00, 5'b00000, 3'd0, 3'b111));
    applyStimulus("ill7End",1'b1, 1'b0, 16'h7000, ZERO);

    applyStimulus("andT0",  1'b1, 1'b1, 16'h4500, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("andT1",  1'b1, 1'b0, 16'h4500, expVec(13'h0004, 1'b0, 8'h00, 5'b10000, 3'd0, 3'b100));
    applyStimulus("andT2",  1'b1, 1'b0, 16'h4500, expVec(13'h0010, 1'b0, 8'h00, 5'b00100, 3'd2, 3'b100));
    applyStimulus("andT3",  1'b1, 1'b0, 16'h4500, expVec(13'h0200, 1'b0, 8'h04, 5'b00000, 3'd0, 3'b110));

    applyStimulus("orT0",   1'b1, 1'b1, 16'h5040, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("orT1",   1'b1, 1'b0, 16'h5040, expVec(13'h0001, 1'b0, 8'h00, 5'b10000, 3'd0, 3'b100));
    applyStimulus("orT2",   1'b1, 1'b0, 16'h5040, expVec(13'h0002, 1'b0, 8'h00, 5'b00010, 3'd3, 3'b100));
    applyStimulus("orT3",   1'b1, 1'b0, 16'h5040, expVec(13'h0400, 1'b0, 8'h01, 5'b00000, 3'd0, 3'b110));

    applyStimulus("addXXT0",1'b1, 1'b1, 16'h26C0, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("addXXT1",1'b1, 1'b0, 16'h26C0, expVec(13'h0008, 1'b0, 8'h00, 5'b10000, 3'd0, 3'b100));
    applyStimulus("addXXT2",1'b1, 1'b0, 16'h26C0, expVec(13'h0008, 1'b0, 8'h00, 5'b01000, 3'd0, 3'b100));
    applyStimulus("addXXT3",1'b1, 1'b0, 16'h26C0, expVec(13'h0100, 1'b0, 8'h08, 5'b00000, 3'd0, 3'b110));

    applyStimulus("subT0",  1'b1, 1'b1, 16'h3880, expVec(13'h0000, 1'b1, 8'h00, 5'b00000, 3'd0, 3'b000));
    applyStimulus("subT1",  1'b1, 1'b1, 16'h3880, expVec(13'h0010, 1'b0, 8'h00, 5'b10000, 3'd0, 3'b100));
    applyStimulus("subRst", 1'b0, 1'b1, 16'h3880, ZERO);
    applyStimulus("subAft0",1'b1, 1'b0, 16'h3880, ZERO);
    applyStimulus("subAft1",1'b1, 1'b0, 16'h3880, ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
